// File: rtl/alu_shift_pkg.sv
// Shared definitions for the pipelined shifter: operation encodings and the
// helper that derives the shift-amount width (equal to the number of stages).
package alu_shift_pkg;

  typedef enum logic [1:0] {
    MODE_SLL  = 2'b00,
    MODE_SRL  = 2'b01,
    MODE_SRA  = 2'b10,
    MODE_ROTR = 2'b11
  } mode_e;

  localparam int unsigned MODE_W = 2;

  function automatic int unsigned shamt_width(input int unsigned width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/alu_shift_pipe_if.sv
// Handshake bundle for alu_shift_pipe.
//   in_valid/in_ready      : upstream operation handshake
//   data_operandA          : operand to shift
//   ctrl_shiftamt/ctrl_mode: shift amount and operation
//   in_tag                 : sideband returned with the result
//   out_valid/out_ready    : downstream result handshake
//   data_result/out_tag    : shifted result and its tag
// master: the side that produces operations and consumes results.
// slave : the shifter itself.
interface alu_shift_pipe_if
  import alu_shift_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 4
);
  localparam int unsigned SHAMT_W = shamt_width(WIDTH);

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   data_operandA;
  logic [SHAMT_W-1:0] ctrl_shiftamt;
  logic [MODE_W-1:0]  ctrl_mode;
  logic [TAG_W-1:0]   in_tag;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   data_result;
  logic [TAG_W-1:0]   out_tag;

  modport master (
    output in_valid, data_operandA, ctrl_shiftamt, ctrl_mode, in_tag, out_ready,
    input  in_ready, out_valid, data_result, out_tag
  );

  modport slave (
    input  in_valid, data_operandA, ctrl_shiftamt, ctrl_mode, in_tag, out_ready,
    output in_ready, out_valid, data_result, out_tag
  );

endinterface

// File: rtl/alu_shift_stage.sv
// One registered step of the logarithmic shifter. Shifts the upstream data by
// STEP bits when the matching shift-amount bit is set, else passes it through.
//   clock, reset_n : clock and synchronous active-low reset
//   up_*           : upstream valid/data/tag/mode/shamt/sign bundle
//   advance        : downstream will take this stage's contents this cycle
//   load           : this stage takes the upstream bundle this cycle
//   valid..sign    : registered output bundle
module alu_shift_stage
  import alu_shift_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 4,
  parameter int unsigned STEP  = 1
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          up_valid,
  input  logic [WIDTH-1:0]              up_data,
  input  logic [TAG_W-1:0]              up_tag,
  input  mode_e                         up_mode,
  input  logic [shamt_width(WIDTH)-1:0] up_shamt,
  input  logic                          up_sign,
  input  logic                          advance,
  output logic                          load,
  output logic                          valid,
  output logic [WIDTH-1:0]              data,
  output logic [TAG_W-1:0]              tag,
  output mode_e                         mode,
  output logic [shamt_width(WIDTH)-1:0] shamt,
  output logic                          sign
);
  localparam int unsigned SHAMT_W = shamt_width(WIDTH);
  localparam int unsigned BIT     = $clog2(STEP);

  logic               valid_q;
  logic [WIDTH-1:0]   data_q;
  logic [TAG_W-1:0]   tag_q;
  mode_e              mode_q;
  logic [SHAMT_W-1:0] shamt_q;
  logic               sign_q;

  logic [WIDTH-1:0]   shifted;
  logic [WIDTH-1:0]   data_d;

  always_comb begin
    shifted = up_data;
    unique case (up_mode)
      MODE_SLL:  shifted = up_data << STEP;
      MODE_SRL:  shifted = up_data >> STEP;
      // Fill from the operand's original MSB, carried alongside the data.
      MODE_SRA:  shifted = {{STEP{up_sign}}, up_data[WIDTH-1:STEP]};
      MODE_ROTR: shifted = {up_data[STEP-1:0], up_data[WIDTH-1:STEP]};
    endcase
    data_d = up_shamt[BIT] ? shifted : up_data;
  end

  // Take new contents when empty or when the current contents move on.
  assign load = !valid_q || advance;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      tag_q   <= '0;
      mode_q  <= MODE_SLL;
      shamt_q <= '0;
      sign_q  <= 1'b0;
    end else if (load) begin
      valid_q <= up_valid;
      // Payload only moves with a real operation so idle stages stay quiet.
      if (up_valid) begin
        data_q  <= data_d;
        tag_q   <= up_tag;
        mode_q  <= up_mode;
        shamt_q <= up_shamt;
        sign_q  <= up_sign;
      end
    end
  end

  assign valid = valid_q;
  assign data  = data_q;
  assign tag   = tag_q;
  assign mode  = mode_q;
  assign shamt = shamt_q;
  assign sign  = sign_q;

endmodule

// File: rtl/alu_shift_pipe.sv
// Pipelined multi-mode shifter (SLL, SRL, SRA, ROTR), one log stage per
// shift-amount bit, largest step first, one result per cycle with full
// valid/ready backpressure and an in-order sideband tag.
//   clock   : sole clock
//   reset_n : synchronous active-low reset, discards in-flight operations
//   bus     : operation/result handshake bundle (slave side)
module alu_shift_pipe
  import alu_shift_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = shamt_width(WIDTH),
  parameter int unsigned TAG_W   = 4
) (
  input logic              clock,
  input logic              reset_n,
  alu_shift_pipe_if.slave  bus
);
  // Index 0 is the input bundle, index k+1 is the output of stage k.
  logic [SHAMT_W:0]   valid_c;
  logic [SHAMT_W:0]   load_c;
  logic [SHAMT_W:0]   sign_c;
  logic [WIDTH-1:0]   data_c  [SHAMT_W+1];
  logic [TAG_W-1:0]   tag_c   [SHAMT_W+1];
  mode_e              mode_c  [SHAMT_W+1];
  logic [SHAMT_W-1:0] shamt_c [SHAMT_W+1];

  assign valid_c[0] = bus.in_valid;
  assign data_c[0]  = bus.data_operandA;
  assign tag_c[0]   = bus.in_tag;
  assign mode_c[0]  = mode_e'(bus.ctrl_mode);
  assign shamt_c[0] = bus.ctrl_shiftamt;
  assign sign_c[0]  = bus.data_operandA[WIDTH-1];

  // The last stage advances whenever downstream accepts.
  assign load_c[SHAMT_W] = bus.out_ready;

  for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
    alu_shift_stage #(
      .WIDTH (WIDTH),
      .TAG_W (TAG_W),
      .STEP  (1 << (SHAMT_W - 1 - k))
    ) u_stage (
      .clock    (clock),
      .reset_n  (reset_n),
      .up_valid (valid_c[k]),
      .up_data  (data_c[k]),
      .up_tag   (tag_c[k]),
      .up_mode  (mode_c[k]),
      .up_shamt (shamt_c[k]),
      .up_sign  (sign_c[k]),
      .advance  (load_c[k+1]),
      .load     (load_c[k]),
      .valid    (valid_c[k+1]),
      .data     (data_c[k+1]),
      .tag      (tag_c[k+1]),
      .mode     (mode_c[k+1]),
      .shamt    (shamt_c[k+1]),
      .sign     (sign_c[k+1])
    );
  end

  assign bus.in_ready    = load_c[0];
  assign bus.out_valid   = valid_c[SHAMT_W];
  assign bus.data_result = data_c[SHAMT_W];
  assign bus.out_tag     = tag_c[SHAMT_W];

  // Control carried into the last stage has no consumer past the pipe.
  logic unused_tail;
  assign unused_tail = ^{mode_c[SHAMT_W], shamt_c[SHAMT_W], sign_c[SHAMT_W]};

endmodule

// File: tb/tb_alu_shift_pipe.sv
module tb_alu_shift_pipe;
  import alu_shift_pkg::*;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned TAG_W   = 4;
  localparam int unsigned SHAMT_W = 5;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  alu_shift_pipe_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

  alu_shift_pipe #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W),
    .TAG_W   (TAG_W)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [31:0] data;
    logic [3:0]  tag;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference: plain arithmetic on the whole shift amount.
  function automatic logic [31:0] ref_shift(input logic [31:0] a, input int sh,
                                            input logic [1:0] m);
    logic [63:0] dbl;
    case (m)
      2'b00:   return a << sh;
      2'b01:   return a >> sh;
      2'b10:   return $signed(a) >>> sh;
      default: begin
        dbl = {a, a} >> sh;
        return dbl[31:0];
      end
    endcase
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_op(input logic [31:0] a, input int sh, input logic [1:0] m,
                          input logic [3:0] t);
    bus.in_valid      = 1'b1;
    bus.data_operandA = a;
    bus.ctrl_shiftamt = sh[4:0];
    bus.ctrl_mode     = m;
    bus.in_tag        = t;
  endtask

  task automatic push_expected();
    exp_t e;
    e.data = ref_shift(bus.data_operandA, int'(bus.ctrl_shiftamt), bus.ctrl_mode);
    e.tag  = bus.in_tag;
    exp_q.push_back(e);
  endtask

  // Issue one operation into an idle pipe and observe when/what comes out.
  task automatic issue_one(input logic [31:0] a, input int sh, input logic [1:0] m,
                           input logic [3:0] t, output int lat, output logic [31:0] r,
                           output logic [3:0] rt);
    bus.out_ready = 1'b1;
    drive_op(a, sh, m, t);
    #1;
    tick();
    bus.in_valid = 1'b0;
    lat = -1;
    r   = 'x;
    rt  = 'x;
    for (int c = 1; c <= 20; c++) begin
      if (bus.out_valid === 1'b1) begin
        lat = c;
        r   = bus.data_result;
        rt  = bus.out_tag;
        break;
      end
      tick();
    end
    tick();
  endtask

  task automatic test_reset();
    bus.in_valid      = 1'b0;
    bus.data_operandA = '0;
    bus.ctrl_shiftamt = '0;
    bus.ctrl_mode     = '0;
    bus.in_tag        = '0;
    bus.out_ready     = 1'b0;
    reset_n           = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid);
    end
    checks++;
    if (bus.data_result !== 32'h0) begin
      errors++;
      $display("FAIL reset_data_result: got %h expected 00000000", bus.data_result);
    end
    checks++;
    if (bus.out_tag !== 4'h0) begin
      errors++;
      $display("FAIL reset_out_tag: got %h expected 0", bus.out_tag);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
    end
    tick();
  endtask

  task automatic test_directed();
    logic [31:0] va [10] = '{32'h80000000, 32'h7FFFFFFF, 32'h00000001, 32'h6A09E667,
                             32'h0000000F, 32'h80000000, 32'h12345678, 32'h12345678,
                             32'h12345678, 32'h12345678};
    int          vs [10] = '{4, 31, 7, 2, 31, 31, 0, 0, 0, 0};
    logic [1:0]  vm [10] = '{2'b10, 2'b10, 2'b11, 2'b11, 2'b00, 2'b01, 2'b00, 2'b01,
                             2'b10, 2'b11};
    logic [31:0] ve [10] = '{32'hF8000000, 32'h00000000, 32'h02000000, 32'hDA827999,
                             32'h80000000, 32'h00000001, 32'h12345678, 32'h12345678,
                             32'h12345678, 32'h12345678};
    int          lat;
    logic [31:0] r;
    logic [3:0]  rt;
    logic [3:0]  t;
    for (int i = 0; i < 10; i++) begin
      t = (i == 0) ? 4'd3 : 4'(i);
      issue_one(va[i], vs[i], vm[i], t, lat, r, rt);
      checks++;
      if (lat != 5) begin
        errors++;
        $display("FAIL directed%0d_latency: got %0d expected 5", i, lat);
      end
      checks++;
      if (r !== ve[i]) begin
        errors++;
        $display("FAIL directed%0d_data: got %h expected %h", i, r, ve[i]);
      end
      checks++;
      if (rt !== t) begin
        errors++;
        $display("FAIL directed%0d_tag: got %h expected %h", i, rt, t);
      end
    end
  endtask

  task automatic test_back_to_back();
    int   issued = 0;
    int   got    = 0;
    int   first  = -1;
    int   cyc    = 0;
    bit   in_ok  = 1'b1;
    exp_t e;
    exp_q.delete();
    bus.out_ready = 1'b1;
    while ((issued < 16 || got < 16) && cyc < 80) begin
      if (issued < 16) drive_op($urandom(), int'($urandom_range(0, 31)),
                                2'($urandom_range(0, 3)), 4'(issued));
      else bus.in_valid = 1'b0;
      #1;
      if (issued < 16 && bus.in_ready !== 1'b1) in_ok = 1'b0;
      if (bus.out_valid === 1'b1) begin
        if (first < 0) first = cyc;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL b2b_unexpected: got tag %h expected no output", bus.out_tag);
        end else begin
          e = exp_q.pop_front();
          if (bus.data_result !== e.data || bus.out_tag !== e.tag || cyc != first + got) begin
            errors++;
            $display("FAIL b2b_result%0d: got %h/tag %h at cycle %0d expected %h/tag %h at %0d",
                     got, bus.data_result, bus.out_tag, cyc, e.data, e.tag, first + got);
          end
        end
        got++;
      end
      if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin
        push_expected();
        issued++;
      end
      tick();
      cyc++;
    end
    bus.in_valid = 1'b0;
    checks++;
    if (!in_ok) begin
      errors++;
      $display("FAIL b2b_in_ready: got 0 during flow expected 1");
    end
    checks++;
    if (got != 16) begin
      errors++;
      $display("FAIL b2b_count: got %0d results expected 16", got);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] oa [7];
    int          os [7];
    logic [1:0]  om [7];
    int          issued = 0;
    int          got    = 0;
    int          cyc    = 0;
    bit          snap   = 1'b0;
    bit          stable = 1'b1;
    logic [31:0] snap_d;
    logic [3:0]  snap_t;
    exp_t        e;
    for (int i = 0; i < 7; i++) begin
      oa[i] = $urandom();
      os[i] = int'($urandom_range(0, 31));
      om[i] = 2'($urandom_range(0, 3));
    end
    exp_q.delete();
    bus.out_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (issued < 7) drive_op(oa[issued], os[issued], om[issued], 4'(issued + 8));
      #1;
      if (snap) begin
        if (bus.out_valid !== 1'b1 || bus.data_result !== snap_d || bus.out_tag !== snap_t)
          stable = 1'b0;
      end else if (bus.out_valid === 1'b1) begin
        snap   = 1'b1;
        snap_d = bus.data_result;
        snap_t = bus.out_tag;
      end
      if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin
        push_expected();
        issued++;
      end
      tick();
    end
    #1;
    checks++;
    if (issued != 5) begin
      errors++;
      $display("FAIL bp_accepted: got %0d expected 5", issued);
    end
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_in_ready_full: got %b expected 0", bus.in_ready);
    end
    checks++;
    if (!snap || !stable) begin
      errors++;
      $display("FAIL bp_hold_stable: got seen=%0d stable=%0d expected 1/1", snap, stable);
    end
    bus.out_ready = 1'b1;
    while ((issued < 7 || got < 7) && cyc < 60) begin
      if (issued < 7) drive_op(oa[issued], os[issued], om[issued], 4'(issued + 8));
      else bus.in_valid = 1'b0;
      #1;
      if (bus.out_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL bp_unexpected: got tag %h expected no output", bus.out_tag);
        end else begin
          e = exp_q.pop_front();
          if (bus.data_result !== e.data || bus.out_tag !== e.tag) begin
            errors++;
            $display("FAIL bp_result%0d: got %h/tag %h expected %h/tag %h",
                     got, bus.data_result, bus.out_tag, e.data, e.tag);
          end
        end
        got++;
      end
      if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin
        push_expected();
        issued++;
      end
      tick();
      cyc++;
    end
    bus.in_valid = 1'b0;
    checks++;
    if (got != 7) begin
      errors++;
      $display("FAIL bp_drain_count: got %0d expected 7", got);
    end
  endtask

  task automatic test_reset_midstream();
    bit          ghost = 1'b0;
    int          lat;
    logic [31:0] r;
    logic [3:0]  rt;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_op($urandom(), int'($urandom_range(1, 31)), 2'($urandom_range(0, 3)), 4'(i + 1));
      tick();
    end
    bus.in_valid = 1'b0;
    reset_n      = 1'b0;
    tick();
    reset_n = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_out_valid: got %b expected 0", bus.out_valid);
    end
    checks++;
    if (bus.data_result !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset_data: got %h expected 00000000", bus.data_result);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_in_ready: got %b expected 1", bus.in_ready);
    end
    for (int c = 0; c < 10; c++) begin
      if (bus.out_valid !== 1'b0) ghost = 1'b1;
      tick();
    end
    checks++;
    if (ghost) begin
      errors++;
      $display("FAIL mid_reset_ghost: got an output expected none");
    end
    issue_one(32'hC0000001, 1, 2'b10, 4'hA, lat, r, rt);
    checks++;
    if (lat != 5) begin
      errors++;
      $display("FAIL mid_reset_latency: got %0d expected 5", lat);
    end
    checks++;
    if (r !== 32'hE0000000 || rt !== 4'hA) begin
      errors++;
      $display("FAIL mid_reset_after: got %h/tag %h expected e0000000/tag a", r, rt);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
